// File: rtl/muldiv_iter_unit.sv
// ---------------------------------------------------------------------------
// muldiv_iter_unit
//   Iterative RV32M multiply/divide unit for the EX stage. Multiplies use a
//   radix-2 shift-add over a 2*WIDTH accumulator; divides use restoring
//   division. Each produces one bit per cycle. Operand magnitudes are taken
//   on acceptance, and the sign is fixed up in a single final cycle.
//
// Ports
//   CLK       system clock, rising edge
//   RESETN    asynchronous active-low reset
//   START     request, taken only while idle and not flushed
//   FLUSH     synchronous abort of any operation in flight
//   OP        funct3 operation code (MUL..REMU)
//   DATA1     rs1 operand, sampled at acceptance
//   DATA2     rs2 operand, sampled at acceptance
//   BUSY      operation in progress
//   DONE      one-cycle pulse, RESULT valid
//   RESULT    registered result, held until the next DONE
//   DIV_ZERO  registered with DONE, divide op had DATA2 = 0
// ---------------------------------------------------------------------------
module muldiv_iter_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             START,
   input  logic             FLUSH,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT,
   output logic             DIV_ZERO
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [WIDTH-1:0]   ONE_W    = 1;
   localparam logic [2*WIDTH-1:0] ONE_2W   = 1;
   localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_ONE  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Two's-complement negation helpers for the final sign fix-up.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + ONE_2W;
   endfunction

   // ---- acceptance decode (operands as presented on START) ----
   logic signed [WIDTH-1:0] data1_s, data2_s;
   logic                    sgn1, sgn2, neg1, neg2;
   logic                    is_div, div_zero_in, div_ovf_in, fast, neg_res_in;
   logic [WIDTH-1:0]        mag1, mag2;
   logic                    accept;

   always_comb begin
      data1_s     = DATA1;
      data2_s     = DATA2;
      sgn1        = (OP == OP_MULH) || (OP == OP_MULHSU) || (OP == OP_DIV) || (OP == OP_REM);
      sgn2        = (OP == OP_MULH) || (OP == OP_DIV) || (OP == OP_REM);
      neg1        = sgn1 && (data1_s < 0);
      neg2        = sgn2 && (data2_s < 0);
      mag1        = neg1 ? neg_w(DATA1) : DATA1;
      mag2        = neg2 ? neg_w(DATA2) : DATA2;
      is_div      = OP[2];
      div_zero_in = is_div && (DATA2 == '0);
      // Only the signed divides (OP[0]=0) can overflow.
      div_ovf_in  = is_div && !OP[0] && (DATA1 == MIN_NEG) && (DATA2 == '1);
      fast        = div_zero_in || div_ovf_in;
      case (OP)
         OP_MULH, OP_DIV:   neg_res_in = neg1 ^ neg2;
         OP_MULHSU, OP_REM: neg_res_in = neg1;
         default:           neg_res_in = 1'b0;
      endcase
   end

   assign accept = (state == IDLE) && START && !FLUSH;

   // ---- control state ----
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (FLUSH) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (START) state_nxt = fast ? FIN : CALC;
            CALC:    if (cnt == CNT_ONE) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign BUSY = (state != IDLE);

   // ---- iteration datapath ----
   logic [2:0]         op_q;
   logic               neg_q, dz_q;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   acc_hi, acc_lo;
   logic [WIDTH:0]     mul_sum, div_trial, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next;

   always_comb begin
      acc_hi    = acc[2*WIDTH-1:WIDTH];
      acc_lo    = acc[WIDTH-1:0];
      // Shift-add: add multiplicand into the high half when the current
      // multiplier bit (acc LSB) is set, then shift the whole pair right.
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
      // Restoring divide: partial remainder in the high half, dividend bits
      // shifting out of the low half while quotient bits shift in.
      div_trial = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opnd};
      // A borrow into bit WIDTH means trial < divisor: keep the remainder.
      div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc_lo[WIDTH-2:0], 1'b1};
   end

   // ---- final sign correction and result select ----
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   div_word, fin_result;

   always_comb begin
      prod       = neg_q ? neg_2w(acc) : acc;
      div_word   = op_q[1] ? acc_hi : acc_lo;
      fin_result = prod[WIDTH-1:0];
      if (op_q[2])
         fin_result = neg_q ? neg_w(div_word) : div_word;
      else if (op_q[1:0] != 2'b00)
         fin_result = prod[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         op_q     <= '0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         RESULT   <= '0;
         DONE     <= 1'b0;
         DIV_ZERO <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (accept) begin
            op_q  <= OP;
            neg_q <= fast ? 1'b0 : neg_res_in;
            dz_q  <= div_zero_in;
            cnt   <= CNT_INIT;
            if (div_zero_in) begin
               // Quotient all ones in the low half, remainder = dividend.
               acc  <= {DATA1, {WIDTH{1'b1}}};
               opnd <= '0;
            end else if (div_ovf_in) begin
               acc  <= {{WIDTH{1'b0}}, DATA1};
               opnd <= '0;
            end else if (is_div) begin
               acc  <= {{WIDTH{1'b0}}, mag1};
               opnd <= mag2;
            end else begin
               acc  <= {{WIDTH{1'b0}}, mag2};
               opnd <= mag1;
            end
         end else if (!FLUSH && (state == CALC)) begin
            cnt <= cnt - CNT_ONE;
            acc <= op_q[2] ? div_next : mul_next;
         end else if (!FLUSH && (state == FIN)) begin
            RESULT   <= fin_result;
            DIV_ZERO <= dz_q;
            DONE     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_iter_unit
//   Scoreboard bench for muldiv_iter_unit (WIDTH=32). The stimulus process
//   pushes the reference result, DIV_ZERO and DONE cycle for every accepted
//   operation; a monitor pops and compares each time DONE is seen.
// ---------------------------------------------------------------------------
module tb_muldiv_iter_unit;

   localparam int W = 32;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
   localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

   logic         CLK = 1'b0;
   logic         RESETN, START, FLUSH;
   logic [2:0]   OP;
   logic [W-1:0] DATA1, DATA2, RESULT;
   logic         BUSY, DONE, DIV_ZERO;

   muldiv_iter_unit #(.WIDTH(W)) dut (
      .CLK(CLK), .RESETN(RESETN), .START(START), .FLUSH(FLUSH), .OP(OP),
      .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE),
      .RESULT(RESULT), .DIV_ZERO(DIV_ZERO)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_res = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Reference model: RV32M semantics with plain 64-bit arithmetic.
   function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic dz);
      longint      sa, sb_, ua, ub, p;
      logic [63:0] pu;
      logic        ovf;
      sa  = $signed(a);
      sb_ = $signed(b);
      ua  = a;
      ub  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      dz  = 1'b0;
      r   = 32'd0;
      case (op)
         MUL:    begin p = sa * sb_; r = p[31:0];  end
         MULH:   begin p = sa * sb_; r = p[63:32]; end
         MULHSU: begin p = sa * ub;  r = p[63:32]; end
         MULHU:  begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
         DIV: begin
            if (b == 0)   begin r = 32'hFFFF_FFFF; dz = 1'b1; end
            else if (ovf) r = a;
            else begin p = sa / sb_; r = p[31:0]; end
         end
         DIVU: begin
            if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
            else r = a / b;
         end
         REM: begin
            if (b == 0)   begin r = a; dz = 1'b1; end
            else if (ovf) r = 32'd0;
            else begin p = sa % sb_; r = p[31:0]; end
         end
         default: begin
            if (b == 0) begin r = a; dz = 1'b1; end
            else r = a % b;
         end
      endcase
   endfunction

   function automatic logic [31:0] rnd32();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'd0;
         1:       v = 32'd1;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h8000_0000;
         4:       v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Called at a negedge while the unit is idle; returns just after the
   // acceptance edge with operands scrambled.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res);
      exp_t e;
      int   lat;
      ref_model(op, a, b, e.res, e.dz);
      lat   = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : W + 1;
      e.cyc = cyc + 1 + lat;
      OP    = op;
      DATA1 = a;
      DATA2 = b;
      START = 1'b1;
      sb.push_back(e);
      res   = e.res;
      @(posedge CLK);
      #1;
      START = 1'b0;
      OP    = 3'($urandom_range(0, 7));
      DATA1 = $urandom;
      DATA2 = $urandom;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (n < 100) begin
         @(negedge CLK);
         if (!BUSY) break;
         n++;
      end
      if (n >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL busy_timeout: BUSY high for %0d cycles, required to drop", n);
      end
   endtask

   task automatic do_dir(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic dz, input int lat);
      logic [31:0] er;
      int          n;
      issue(op, a, b, er);
      wait_idle(n);
      check({name, "_busy_cycles"}, n, lat);
      check({name, "_result"}, RESULT, r);
      check({name, "_div_zero"}, DIV_ZERO, dz);
      last_res = r;
   endtask

   // Monitor: compare every DONE against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RESETN === 1'b1 && DONE === 1'b1) begin
            check("busy_with_done", BUSY, 0);
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got DONE=1 RESULT=0x%0h, required no DONE", RESULT);
            end else begin
               e = sb.pop_front();
               check("sb_result", RESULT, e.res);
               check("sb_div_zero", DIV_ZERO, e.dz);
               check("sb_done_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] er;
      int          n;
      RESETN = 1'b0;
      START  = 1'b0;
      FLUSH  = 1'b0;
      OP     = 3'd0;
      DATA1  = '0;
      DATA2  = '0;
      repeat (3) @(negedge CLK);
      check("reset_busy", BUSY, 0);
      check("reset_done", DONE, 0);
      check("reset_result", RESULT, 0);
      check("reset_div_zero", DIV_ZERO, 0);
      RESETN = 1'b1;
      @(negedge CLK);

      // Directed cases, issued back-to-back in each DONE cycle.
      do_dir("mul_7x6",       MUL,    32'd7,          32'd6,          32'h0000_002A, 1'b0, 33);
      do_dir("mulh_min",      MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 1'b0, 33);
      do_dir("mulhsu_ones",   MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 33);
      do_dir("mulhu_ones",    MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0, 33);
      do_dir("div_m7_2",      DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0, 33);
      do_dir("rem_m7_2",      REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0, 33);
      do_dir("divu_100_7",    DIVU,   32'd100,        32'd7,          32'd14,        1'b0, 33);
      do_dir("remu_100_7",    REMU,   32'd100,        32'd7,          32'd2,         1'b0, 33);
      do_dir("div_by_zero",   DIV,    32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, 1);
      do_dir("rem_by_zero",   REM,    32'd5,          32'd0,          32'd5,         1'b1, 1);
      do_dir("div_overflow",  DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0, 1);
      do_dir("rem_overflow",  REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1'b0, 1);
      do_dir("divu_min_ones", DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1'b0, 33);
      do_dir("remu_by_zero",  REMU,   32'd9,          32'd0,          32'd9,         1'b1, 1);

      // Flush mid-divide with START asserted on the same edge.
      issue(DIVU, 32'd1000, 32'd7, er);
      repeat (10) @(negedge CLK);
      FLUSH = 1'b1;
      START = 1'b1;
      OP    = MUL;
      DATA1 = 32'd9;
      DATA2 = 32'd9;
      void'(sb.pop_back());
      @(posedge CLK);
      #1;
      FLUSH = 1'b0;
      START = 1'b0;
      check("flush_busy", BUSY, 0);
      check("flush_done", DONE, 0);
      check("flush_result_held", RESULT, last_res);
      check("flush_div_zero_held", DIV_ZERO, 1);
      repeat (40) @(negedge CLK);
      check("flush_busy_later", BUSY, 0);
      check("flush_result_later", RESULT, last_res);
      do_dir("mul_after_flush", MUL, 32'd3, 32'd5, 32'd15, 1'b0, 33);

      // START pulses while busy must be ignored.
      issue(DIVU, 32'd100, 32'd7, er);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         START = 1'b1;
         OP    = MUL;
         DATA1 = $urandom;
         DATA2 = $urandom;
         @(negedge CLK);
         START = 1'b0;
      end
      wait_idle(n);
      check("ignore_start_result", RESULT, 32'd14);
      @(negedge CLK);
      check("ignore_start_no_extra_op", BUSY, 0);
      last_res = 32'd14;

      // Asynchronous reset in the middle of a multiply.
      issue(MUL, 32'd123, 32'd456, er);
      repeat (5) @(negedge CLK);
      void'(sb.pop_back());
      #2;
      RESETN = 1'b0;
      #1;
      check("async_reset_busy", BUSY, 0);
      check("async_reset_done", DONE, 0);
      check("async_reset_result", RESULT, 0);
      check("async_reset_div_zero", DIV_ZERO, 0);
      @(negedge CLK);
      RESETN = 1'b1;
      @(negedge CLK);
      last_res = 32'd0;

      // Randomized operations against the reference model.
      for (int i = 0; i < 200; i++) begin
         issue(3'($urandom_range(0, 7)), rnd32(), rnd32(), er);
         wait_idle(n);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      end

      repeat (3) @(negedge CLK);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
